// File: rtl/otter_fetch_pc.sv
// otter_fetch_pc: instruction fetch program counter with trap/redirect targeting and a one-deep pending target.
// Define OTTER_PC_COMPRESSED_EN to enable 2-byte alignment and 16-bit instruction increments.
module otter_fetch_pc #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            is_compressed,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] addr_inc,
  output logic            misaligned
);

`ifdef OTTER_PC_COMPRESSED_EN
  localparam int ALIGN_BITS = 1;
`else
  localparam int ALIGN_BITS = 2;
`endif

  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;
  localparam logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_VEC) & ALIGN_MASK;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] pend_reg, pend_next;
  logic            mis_reg, mis_next;

  logic            accept;
  logic            open_slot;
  logic            tgt_valid;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] apply_tgt;
  logic            apply_mis;

  assign fetch_valid = (state_reg != BOOT) && !stall;
  assign accept      = fetch_valid && fetch_ready;
  // Nothing is left outstanding after this edge, so addr is free to move.
  assign open_slot   = !fetch_valid || fetch_ready;

  assign tgt_valid = trap_valid || redirect_valid;
  assign tgt_raw   = trap_valid ? trap_addr : redirect_addr;
  assign apply_tgt = (state_reg == PEND && !tgt_valid) ? pend_reg : tgt_raw;

`ifdef OTTER_PC_COMPRESSED_EN
  assign addr_inc  = addr_reg + (is_compressed ? XLEN'(2) : XLEN'(4));
  // Only bit 0 is ever cleared here, and bit 0 never counts as misaligned.
  assign apply_mis = 1'b0;
`else
  logic unused_is_compressed;
  assign unused_is_compressed = is_compressed;
  assign addr_inc  = addr_reg + XLEN'(4);
  assign apply_mis = apply_tgt[1];
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    pend_next  = pend_reg;
    mis_next   = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (tgt_valid) begin
          if (!open_slot) begin
            pend_next  = tgt_raw;
            state_next = PEND;
          end else begin
            addr_next = apply_tgt & ALIGN_MASK;
            mis_next  = apply_mis;
          end
        end else if (accept) begin
          addr_next = addr_inc;
        end
      end
      PEND: begin
        if (open_slot) begin
          addr_next  = apply_tgt & ALIGN_MASK;
          mis_next   = apply_mis;
          state_next = RUN;
        end else if (tgt_valid) begin
          pend_next = tgt_raw;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      addr_reg  <= RESET_ADDR;
      pend_reg  <= '0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      pend_reg  <= pend_next;
      mis_reg   <= mis_next;
    end
  end

  assign addr       = addr_reg;
  assign misaligned = mis_reg;

endmodule
